// File: rtl/unit_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : unit_tick_scheduler
// Brief    : 16-slot unit table; per game tick advances live units, places one
//            pending spawn, then pulses game_scen for a coherent snapshot.
// Revision : 1.0
// ============================================================================
module unit_tick_scheduler #(
  parameter int unsigned TICK_FRAMES = 4,
  parameter logic [8:0]  SPEED       = 9'd2,
  parameter logic [8:0]  MAX_LOC     = 9'd400,
  parameter logic [9:0]  VBLANK_LINE = 10'd516
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic [9:0]   vCount,
  input  logic         spawn_valid,
  input  logic [1:0]   spawn_type,
  output logic         spawn_ready,
  output logic         spawn_full,
  output logic         escape,
  output logic [7:0]   escape_count,
  output logic         game_scen,
  output logic [143:0] unit_loc_flat,
  output logic [31:0]  unit_type_flat
);

  localparam int                c_SLOTS      = 16;
  localparam int unsigned       c_CNT_W      = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_FRAME = c_CNT_W'(TICK_FRAMES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ADVANCE = 2'd1,
    S_SPAWN   = 2'd2,
    S_COMMIT  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic [3:0]           r_idx;
  logic                 r_hitD;
  logic [c_CNT_W-1:0]   r_frameCnt;
  logic                 r_pending;
  logic [1:0]           r_pendType;
  logic [7:0]           r_escCount;
  logic [8:0]           r_loc  [c_SLOTS];
  logic [1:0]           r_type [c_SLOTS];

  logic                 w_hit;
  logic                 w_frameEdge;
  logic                 w_tick;
  logic                 w_accept;
  logic                 w_live;
  logic [9:0]           w_sum;
  logic                 w_escape;
  logic                 w_place;
  logic                 w_freeFound;
  logic [3:0]           w_freeIdx;

  assign w_hit       = (vCount == VBLANK_LINE);
  assign w_frameEdge = w_hit & ~r_hitD;
  assign w_tick      = w_frameEdge & run & (r_frameCnt == c_LAST_FRAME);
  assign w_accept    = spawn_valid & ~r_pending;

  assign w_live   = (r_type[r_idx] != 2'b00);
  assign w_sum    = {1'b0, r_loc[r_idx]} + {1'b0, SPEED};
  assign w_escape = (r_state == S_ADVANCE) && w_live && (w_sum > {1'b0, MAX_LOC});

  // Slots freed earlier in this same tick are already empty by SPAWN, so they qualify.
  always_comb begin
    w_freeFound = 1'b0;
    w_freeIdx   = 4'd0;
    for (int i = c_SLOTS - 1; i >= 0; i--) begin
      if (r_type[i] == 2'b00) begin
        w_freeFound = 1'b1;
        w_freeIdx   = 4'(i);
      end
    end
  end

  assign w_place = (r_state == S_SPAWN) && r_pending && (r_pendType != 2'b00) && w_freeFound;

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:    if (w_tick) w_stateNext = S_ADVANCE;
      S_ADVANCE: if (r_idx == 4'd15) w_stateNext = S_SPAWN;
      S_SPAWN:   w_stateNext = S_COMMIT;
      S_COMMIT:  w_stateNext = S_IDLE;
      default:   w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 4'd0;
      r_hitD     <= 1'b0;
      r_frameCnt <= '0;
      r_pending  <= 1'b0;
      r_pendType <= 2'b00;
      r_escCount <= 8'd0;
    end else begin
      r_state <= w_stateNext;
      r_hitD  <= w_hit;
      if (r_state == S_IDLE)
        r_idx <= 4'd0;
      else if (r_state == S_ADVANCE)
        r_idx <= r_idx + 4'd1;
      if (w_frameEdge && run)
        r_frameCnt <= (r_frameCnt == c_LAST_FRAME) ? '0 : r_frameCnt + c_CNT_ONE;
      // Accept needs ~pending, so it can never collide with the SPAWN consume.
      if (w_accept) begin
        r_pending  <= 1'b1;
        r_pendType <= spawn_type;
      end else if (r_state == S_SPAWN) begin
        r_pending  <= 1'b0;
      end
      if (w_escape && (r_escCount != 8'hFF))
        r_escCount <= r_escCount + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_SLOTS; i++) begin
        r_loc[i]  <= 9'd0;
        r_type[i] <= 2'b00;
      end
    end else if ((r_state == S_ADVANCE) && w_live) begin
      if (w_escape) begin
        r_loc[r_idx]  <= 9'd0;
        r_type[r_idx] <= 2'b00;
      end else begin
        r_loc[r_idx]  <= w_sum[8:0];
      end
    end else if (w_place) begin
      r_loc[w_freeIdx]  <= 9'd0;
      r_type[w_freeIdx] <= r_pendType;
    end
  end

  assign spawn_ready  = ~r_pending;
  assign spawn_full   = (r_state == S_SPAWN) && r_pending && (r_pendType != 2'b00) && !w_freeFound;
  assign escape       = w_escape;
  assign escape_count = r_escCount;
  assign game_scen    = (r_state == S_COMMIT);

  generate
    for (genvar gi = 0; gi < c_SLOTS; gi++) begin : g_flat
      assign unit_loc_flat[9*gi +: 9]  = r_loc[gi];
      assign unit_type_flat[2*gi +: 2] = r_type[gi];
    end
  endgenerate

endmodule
`default_nettype wire
